// File: rtl/grid_scan_counter.sv
// grid_scan_counter
//   Two-dimensional cascaded scan counter producing (x, y) cell coordinates.
//   x is the fast axis; y steps only when x wraps. Each axis has its own
//   width, start, step and terminal value. Counting direction is selected
//   at runtime, and a synchronous load overrides stepping.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   enable     : advance one step this cycle
//   dir        : 0 = count up, 1 = count down
//   load       : synchronous load of load_x / load_y (clamped to X_MAX / Y_MAX)
//   load_x/y   : load values
//   x, y       : registered coordinates
//   x_carry    : combinational, this step wraps x
//   y_carry    : combinational, this step wraps both x and y (frame wrap)
//   frame_done : registered pulse the cycle after a frame wrap
//
// Optional build macro GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
//   Adds input restart and output running. The counter halts after a frame
//   wrap (enable ignored, carries low) until restart is pulsed.
module grid_scan_counter #(
  parameter int unsigned X_WIDTH     = 6,
  parameter int unsigned Y_WIDTH     = 6,
  parameter int unsigned X_START     = 0,
  parameter int unsigned Y_START     = 0,
  parameter int unsigned X_MAX       = 63,
  parameter int unsigned Y_MAX       = 63,
  parameter int unsigned X_INCREMENT = 1,
  parameter int unsigned Y_INCREMENT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               dir,
  input  logic               load,
  input  logic [X_WIDTH-1:0] load_x,
  input  logic [Y_WIDTH-1:0] load_y,
`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
  input  logic               restart,
  output logic               running,
`endif
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               x_carry,
  output logic               y_carry,
  output logic               frame_done
);

  // Terminal tests run one bit wider than the axis so x + step never wraps.
  localparam logic [X_WIDTH:0]   XS_E = (X_WIDTH+1)'(X_START);
  localparam logic [X_WIDTH:0]   XM_E = (X_WIDTH+1)'(X_MAX);
  localparam logic [X_WIDTH:0]   XI_E = (X_WIDTH+1)'(X_INCREMENT);
  localparam logic [Y_WIDTH:0]   YS_E = (Y_WIDTH+1)'(Y_START);
  localparam logic [Y_WIDTH:0]   YM_E = (Y_WIDTH+1)'(Y_MAX);
  localparam logic [Y_WIDTH:0]   YI_E = (Y_WIDTH+1)'(Y_INCREMENT);

  localparam logic [X_WIDTH-1:0] XS_W = X_WIDTH'(X_START);
  localparam logic [X_WIDTH-1:0] XM_W = X_WIDTH'(X_MAX);
  localparam logic [X_WIDTH-1:0] XI_W = X_WIDTH'(X_INCREMENT);
  localparam logic [Y_WIDTH-1:0] YS_W = Y_WIDTH'(Y_START);
  localparam logic [Y_WIDTH-1:0] YM_W = Y_WIDTH'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] YI_W = Y_WIDTH'(Y_INCREMENT);

  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               frame_done_q, frame_done_d;
  logic               x_term, y_term;
  logic               step_ok;
  logic               step_en;

`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_ok = 1'b0;
    unique case (state_q)
      RUN: begin
        step_ok = 1'b1;
        if (y_carry) state_d = HALT;
      end
      HALT: begin
        if (restart) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign running = (state_q == RUN);
`else
  assign step_ok = 1'b1;
`endif

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    x_term       = 1'b0;
    y_term       = 1'b0;

    if (dir) begin
      x_term = {1'b0, x_q} < (XS_E + XI_E);
      y_term = {1'b0, y_q} < (YS_E + YI_E);
    end else begin
      x_term = ({1'b0, x_q} + XI_E) > XM_E;
      y_term = ({1'b0, y_q} + YI_E) > YM_E;
    end

    step_en      = enable & ~load & ~reset & step_ok;
    x_carry      = step_en & x_term;
    y_carry      = x_carry & y_term;
    frame_done_d = y_carry;

    if (load) begin
      x_d = (load_x > XM_W) ? XM_W : load_x;
      y_d = (load_y > YM_W) ? YM_W : load_y;
    end else if (step_en) begin
      if (x_carry) begin
        x_d = dir ? XM_W : XS_W;
        if (y_carry) begin
          y_d = dir ? YM_W : YS_W;
        end else begin
          y_d = dir ? (y_q - YI_W) : (y_q + YI_W);
        end
      end else begin
        x_d = dir ? (x_q - XI_W) : (x_q + XI_W);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= XS_W;
      y_q          <= YS_W;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_grid_scan_counter.sv
module tb_grid_scan_counter;

  typedef struct {
    int ex;
    int ey;
    int exc;
    int eyc;
    int efd;
    int erun;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       dir;
  logic       load;
  logic [3:0] load_x;
  logic [1:0] load_y;
  logic [3:0] x;
  logic [1:0] y;
  logic       x_carry;
  logic       y_carry;
  logic       frame_done;
`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
  logic       restart;
  logic       running;
`endif

  exp_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  grid_scan_counter #(
    .X_WIDTH(4), .Y_WIDTH(2),
    .X_START(1), .Y_START(0),
    .X_MAX(5),   .Y_MAX(2),
    .X_INCREMENT(2), .Y_INCREMENT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .dir(dir),
    .load(load),
    .load_x(load_x),
    .load_y(load_y),
`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
    .restart(restart),
    .running(running),
`endif
    .x(x),
    .y(y),
    .x_carry(x_carry),
    .y_carry(y_carry),
    .frame_done(frame_done)
  );

  task automatic chk(input string nm, input string f, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0d required=%0d t=%0t", nm, f, act, req, $time);
    end
  endtask

  // Monitor: pops expectations and compares against the live outputs.
  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk(n, "x", int'(x), e.ex);
        chk(n, "y", int'(y), e.ey);
        chk(n, "x_carry", int'(x_carry), e.exc);
        chk(n, "y_carry", int'(y_carry), e.eyc);
        chk(n, "frame_done", int'(frame_done), e.efd);
`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
        chk(n, "running", int'(running), e.erun);
`endif
      end
    end
  end

  function automatic void push(input string nm, input int ex, input int ey,
                               input int exc, input int eyc, input int efd, input int erun);
    exp_t e;
    e.ex = ex; e.ey = ey; e.exc = exc; e.eyc = eyc; e.efd = efd; e.erun = erun;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what the outputs
  // must show before the next rising edge.
  task automatic cyc(input logic en, input logic dr, input logic ld,
                     input logic [3:0] lx, input logic [1:0] ly, input logic rs,
                     input int ex, input int ey, input int exc, input int eyc,
                     input int efd, input int erun, input string nm);
    @(negedge clk);
    enable = en; dir = dr; load = ld; load_x = lx; load_y = ly;
`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
    restart = rs;
`else
    if (rs) $display("note: restart ignored in this build");
`endif
    push(nm, ex, ey, exc, eyc, efd, erun);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : stim
    int s2x [9] = '{1, 3, 5, 1, 3, 5, 1, 3, 5};
    int s2y [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int s2xc[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    int s2yc[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int fd_a;
    int fd_b;

    reset = 1'b1; enable = 1'b1; dir = 1'b1; load = 1'b0;
    load_x = '0; load_y = '0;
`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
    restart = 1'b0;
`endif

    // Reset held with a would-be double carry on the inputs.
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "rst_mask");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "rst_hold");
    reset = 1'b0;

    // Scenario 1: idle.
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "idle");

    // Scenario 2: full up-count frame.
    for (int i = 0; i < 9; i++)
      cyc(1, 0, 0, 0, 0, 0, s2x[i], s2y[i], s2xc[i], s2yc[i], 0, 1, "up_frame");

`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
    // Scenario 6: halted after the frame wrap.
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, "halt_1");
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "halt_2");
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "restart");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "resume");
    cyc(0, 0, 1, 4'd1, 2'd0, 0, 3, 0, 0, 0, 0, 1, "reload_10");
    fd_a = 0;
    fd_b = 0;
`else
    fd_a = 1;
    fd_b = 1;
`endif

    // Scenario 3: down count from (1,0) wraps both axes on the first step.
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 1, 1, fd_a, 1, "down_wrap");
`ifdef GRID_SCAN_COUNTER_STOP_ON_FRAME_EN
    cyc(0, 1, 0, 0, 0, 1, 5, 2, 0, 0, 1, 0, "down_restart");
`endif
    cyc(1, 1, 0, 0, 0, 0, 5, 2, 0, 0, fd_b, 1, "down_5");
    cyc(1, 1, 0, 0, 0, 0, 3, 2, 0, 0, 0, 1, "down_3");
    cyc(1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, "down_1");
    cyc(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, "up_after_down");

    // Scenario 4: load beats enable, clamps, and masks the carry.
    cyc(1, 1, 1, 4'd12, 2'd1, 0, 1, 2, 0, 0, 0, 1, "load_clamp");
    cyc(0, 0, 1, 4'd0, 2'd3, 0, 5, 1, 0, 0, 0, 1, "load_low");
    cyc(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, "step_low");
    cyc(0, 0, 1, 4'd3, 2'd1, 0, 2, 2, 0, 0, 0, 1, "load_31");
    cyc(0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, "at_31");

    // Scenario 5: asynchronous reset in the middle of a cycle.
    @(negedge clk);
    enable = 1'b1; dir = 1'b1; load = 1'b0;
    #1 reset = 1'b1;
    push("async_rst", 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "async_hold");
    reset = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, "post_rst_step");
    cyc(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, "post_rst_3");

    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
